store_buffer: RTL and testbench
===============================

# store_buffer

Write buffer between the single-cycle ARM core's data-memory port and a backing data RAM whose write port may stall. It accepts one word store per cycle from the core (MemWrite/DataAdr/WriteData) into a FIFO. It drains entries in program order over a valid/ready handshake and forwards the newest matching buffered data to loads so the core always reads its own stores. When the FIFO is full and cannot drain, it stalls the core.

## Interface
Parameters:
- DEPTH, 4: number of buffered stores; power of two, at least 2.
- LOGD, $clog2(DEPTH): pointer width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWrite  input  1  store request from the core this cycle.
- DataAdr  input  32  core data address, used for both stores and loads; only bits [31:2] are significant.
- WriteData  input  32  core store data.
- ReadData  output  32  load data returned to the core (combinational).
- Stall  output  1  tells the core to hold PC and retry the store (combinational).
- MemValid  output  1  head entry is presented to the backing RAM.
- MemReady  input  1  backing RAM accepts the head entry this cycle.
- MemAdr  output  32  head entry address, as {adr[31:2], 2'b00}.
- MemWData  output  32  head entry data.
- MemRAdr  output  32  backing RAM read address; equal to DataAdr.
- MemRData  input  32  backing RAM read data (combinational).
- Empty  output  1  no entries buffered.

## Operation
- Storage: circular FIFO of DEPTH entries {adr[31:2], data}, with head pointer, tail pointer and a count (LOGD+1 bits). Pointers wrap modulo DEPTH.
- pop = MemValid & MemReady.
- Stall = MemWrite & (count == DEPTH) & ~pop.
- push = MemWrite & ~Stall.
- Push writes the entry at tail and advances tail. Pop advances head.
- Simultaneous push and pop leave count unchanged. This holds when full: a push is accepted while the head pops.
- MemValid = (count != 0). MemAdr and MemWData come from the head entry. Empty = (count == 0).
- Stores are not coalesced. Repeated stores to one address each occupy an entry and drain in order.
- Forwarding:
  - ReadData is the data of the newest valid entry whose adr equals DataAdr[31:2]. Newest means closest to tail.
  - If no entry matches, ReadData = MemRData.
  - An entry popping this cycle is still valid for forwarding.
  - The store being pushed this cycle is not visible to forwarding.
- ReadData is driven every cycle. The core qualifies it with its own MemtoReg.
- Byte lanes: word stores only. DataAdr[1:0] is ignored.
- Reset, including assertion mid-drain:
  - count, head and tail are 0 and all entries are cleared.
  - MemValid = 0, Stall = 0, Empty = 1, MemAdr = 0, MemWData = 0.
  - Pending stores are discarded.
  - MemValid drops as soon as reset asserts, without waiting for a clock edge.

## Timing
- Latency from push to MemValid is 1 cycle: an entry pushed at edge N is presented after edge N.
- Throughput is 1 push and 1 pop per cycle.
- Handshake: once MemValid is high, MemAdr and MemWData hold stable until the cycle with MemReady high. The block never withdraws MemValid except on reset. MemReady may be high while MemValid is low; that cycle has no effect.
- Stall is combinational from MemWrite, count and MemReady, and is valid in the same cycle. A stalled store is re-presented by the core and accepted in the first cycle it is not stalled.
- Forwarding path: combinational from DataAdr through the DEPTH comparators and the priority select to ReadData.
- The block itself has no combinational path from MemReady to MemValid.

## Structure
- Shared package sb_pkg contains:
  - typedef sb_entry_t {logic [29:0] adr; logic [31:0] data;}
  - constant SB_DEPTH_DEFAULT = 4.
- One sub-module, sb_fwd: combinational newest-match search. Inputs are the entry array, the valid mask, the tail pointer and the load address. Outputs are hit and data. It is instantiated once inside store_buffer.
- The core's arm/top integration adds Stall as the PC-register enable. That change is outside this block.

## Test plan
- Reset: hold reset low with MemWrite=1 -> MemValid=0, Stall=0, Empty=1 and no pushes. Release reset -> the first store is accepted.
- Single store then drain: store 7 to 0x64 with MemReady=0 -> MemValid=1 next cycle, MemAdr=0x64, MemWData=7. Hold MemReady=0 for 3 cycles -> outputs stable. Raise MemReady -> Empty=1 on the next cycle.
- Fill and stall: with MemReady=0, store 1, 2, 3, 4, 5 to 0x60, 0x64, 0x68, 0x6C, 0x70 -> Stall=1 only on the fifth store. Raise MemReady in that cycle -> Stall=0, the fifth store is accepted, count stays 4, and the drain order is 1, 2, 3, 4, 5.
- Forwarding priority: store 0xA then 0xB to 0x60 with MemReady=0, then load 0x60 -> ReadData=0xB. Load 0x62 -> 0xB (low bits ignored). Load 0x80 with MemRData=0x55 -> 0x55.
- Forward during pop: single entry {0x40, 0x9} and a load of 0x40 in the pop cycle -> ReadData=0x9. The following cycle -> ReadData=MemRData.
- Reset mid-drain: 3 entries pending, assert reset between edges -> MemValid=0 immediately. After release, Empty=1 and no stale writes appear.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and defaults for the store buffer and its forwarding search.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sb_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;

  // One buffered word store; the address is kept word-aligned (bits [31:2]).
  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and RAM-side signal bundle of the store buffer.
// Latency: n/a (wiring only).
// Backpressure: Stall toward the core, MemValid/MemReady toward the RAM.
interface store_buffer_if;

  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        MemValid;
  logic        MemReady;
  logic [31:0] MemAdr;
  logic [31:0] MemWData;
  logic [31:0] MemRAdr;
  logic [31:0] MemRData;
  logic        Empty;

  // The store buffer itself.
  modport slave (
    input  MemWrite, DataAdr, WriteData, MemReady, MemRData,
    output ReadData, Stall, MemValid, MemAdr, MemWData, MemRAdr, Empty
  );

  // The core plus backing RAM that surround the buffer.
  modport master (
    output MemWrite, DataAdr, WriteData, MemReady, MemRData,
    input  ReadData, Stall, MemValid, MemAdr, MemWData, MemRAdr, Empty
  );

endinterface

// File: rtl/sb_fwd.sv
// Newest-match search over buffered stores for load forwarding.
// Latency: purely combinational.
// Backpressure: none.
module sb_fwd
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int LOGD  = $clog2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [LOGD-1:0]  tail,
  input  logic [29:0]      adr,
  output logic             hit,
  output logic [31:0]      data
);

  // Walk backwards from the slot just behind tail so the youngest match wins.
  always_comb begin
    logic [LOGD-1:0] idx;
    idx  = '0;
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail - LOGD'(1) - LOGD'(k);
      if (!hit && valid[idx] && (entries[idx].adr == adr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order write buffer between core data port and a stallable RAM, with load forwarding.
// Latency: push at edge N presents on MemValid after edge N; ReadData/Stall combinational.
// Backpressure: MemValid/MemReady drain; Stall to core only when full and head not popping.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int LOGD  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);

  sb_entry_t        entries [DEPTH];
  logic [LOGD-1:0]  head;
  logic [LOGD-1:0]  tail;
  logic [LOGD:0]    count;
  logic             full;
  logic             pop;
  logic             push;
  logic [DEPTH-1:0] valid;
  logic             fwd_hit;
  logic [31:0]      fwd_data;

  assign full         = (count == (LOGD+1)'(DEPTH));
  assign bus.MemValid = (count != '0);
  assign bus.Empty    = (count == '0);
  assign pop          = bus.MemValid & bus.MemReady;
  // A full buffer still takes a store in the cycle its head drains.
  assign bus.Stall    = bus.MemWrite & full & ~pop;
  assign push         = bus.MemWrite & ~bus.Stall;

  assign bus.MemAdr   = {entries[head].adr, 2'b00};
  assign bus.MemWData = entries[head].data;
  assign bus.MemRAdr  = bus.DataAdr;
  assign bus.ReadData = fwd_hit ? fwd_data : bus.MemRData;

  // Occupancy mask: slot i is live when its distance from head is below count.
  always_comb begin
    logic [LOGD-1:0] rel;
    rel   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel      = LOGD'(i) - head;
      valid[i] = ({1'b0, rel} < count);
    end
  end

  sb_fwd #(
    .DEPTH (DEPTH),
    .LOGD  (LOGD)
  ) u_fwd (
    .entries (entries),
    .valid   (valid),
    .tail    (tail),
    .adr     (bus.DataAdr[31:2]),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  // FIFO state: write at tail on push, retire head on pop; reset discards everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[tail] <= '{adr: bus.DataAdr[31:2], data: bus.WriteData};
        tail          <= tail + LOGD'(1);
      end
      if (pop) begin
        head <= head + LOGD'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (LOGD+1)'(1);
        2'b01:   count <= count - (LOGD+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus directed literals.
// Latency: checks combinational outputs each cycle, model advances on each rising edge.
// Backpressure: exercises Stall and MemReady under directed and random patterns.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [29:0] adr;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ent_t        q[$];
  logic [31:0] drained[$];
  logic        exp_push;
  logic        exp_pop;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest buffered store to the same word, else the RAM data.
  function automatic logic [31:0] model_read(input logic [31:0] adr, input logic [31:0] rdata);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].adr == adr[31:2]) return q[i].data;
    end
    return rdata;
  endfunction

  task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] rd);
    bus.MemWrite  = mw;
    bus.DataAdr   = adr;
    bus.WriteData = wd;
    bus.MemReady  = rdy;
    bus.MemRData  = rd;
  endtask

  // Compare every output against the model, then advance the model over one edge.
  task automatic step();
    logic full;
    logic exp_stall;
    ent_t e;
    #1;
    full      = (q.size() == DEPTH);
    exp_pop   = reset && (q.size() != 0) && bus.MemReady;
    exp_stall = reset && bus.MemWrite && full && !exp_pop;
    exp_push  = reset && bus.MemWrite && !exp_stall;
    chk("mem_valid", bus.MemValid, q.size() != 0);
    chk("empty", bus.Empty, q.size() == 0);
    chk("stall", bus.Stall, exp_stall);
    chk("read_data", bus.ReadData, model_read(bus.DataAdr, bus.MemRData));
    chk("mem_radr", bus.MemRAdr, bus.DataAdr);
    if (q.size() != 0) begin
      chk("mem_adr", bus.MemAdr, {q[0].adr, 2'b00});
      chk("mem_wdata", bus.MemWData, q[0].data);
    end
    if (!reset) begin
      chk("rst_mem_adr", bus.MemAdr, 32'h0);
      chk("rst_mem_wdata", bus.MemWData, 32'h0);
    end
    @(posedge clk);
    if (!reset) begin
      q.delete();
    end else begin
      if (exp_pop) begin
        drained.push_back(q[0].data);
        void'(q.pop_front());
      end
      if (exp_push) begin
        e.adr  = bus.DataAdr[31:2];
        e.data = bus.WriteData;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset held with a store request: nothing is taken.
    reset = 1'b0;
    drive(1'b1, 32'h10, 32'h11, 1'b0, 32'hdeadbeef);
    repeat (3) step();
    #1;
    chk("rst_valid_lit", bus.MemValid, 1'b0);
    chk("rst_stall_lit", bus.Stall, 1'b0);
    chk("rst_empty_lit", bus.Empty, 1'b1);

    // First store after release is accepted.
    reset = 1'b1;
    step();
    #1;
    chk("first_valid_lit", bus.MemValid, 1'b1);
    chk("first_adr_lit", bus.MemAdr, 32'h10);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    step();
    #1;
    chk("first_drain_empty", bus.Empty, 1'b1);

    // Single store, held, then drained.
    drive(1'b1, 32'h64, 32'h7, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_valid", bus.MemValid, 1'b1);
      chk("hold_adr", bus.MemAdr, 32'h64);
      chk("hold_wdata", bus.MemWData, 32'h7);
      step();
    end
    bus.MemReady = 1'b1;
    step();
    #1;
    chk("single_empty", bus.Empty, 1'b1);

    // Fill to DEPTH, fifth store stalls until the head drains in the same cycle.
    drained.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h60 + 32'(4 * i), 32'(i + 1), 1'b0, 32'h0);
      #1;
      chk("fill_no_stall", bus.Stall, 1'b0);
      step();
    end
    drive(1'b1, 32'h70, 32'h5, 1'b0, 32'h0);
    #1;
    chk("fifth_stall", bus.Stall, 1'b1);
    bus.MemReady = 1'b1;
    #1;
    chk("fifth_unstall", bus.Stall, 1'b0);
    step();
    drive(1'b1, 32'h74, 32'h6, 1'b0, 32'h0);
    #1;
    chk("still_full", bus.Stall, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    repeat (4) step();
    chk("drain_cnt", drained.size(), 5);
    for (int i = 0; i < 5 && i < drained.size(); i++) begin
      chk("drain_order", drained[i], 32'(i + 1));
    end
    #1;
    chk("fill_empty", bus.Empty, 1'b1);

    // Forwarding priority and ignored low address bits.
    drive(1'b1, 32'h60, 32'hA, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h60, 32'hB, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h60, 32'h0, 1'b0, 32'h1234);
    #1;
    chk("fwd_newest", bus.ReadData, 32'hB);
    bus.DataAdr = 32'h62;
    #1;
    chk("fwd_lowbits", bus.ReadData, 32'hB);
    bus.DataAdr  = 32'h80;
    bus.MemRData = 32'h55;
    #1;
    chk("fwd_miss", bus.ReadData, 32'h55);
    step();
    bus.MemReady = 1'b1;
    repeat (2) step();

    // Forwarding from an entry in its pop cycle.
    drive(1'b1, 32'h40, 32'h9, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h40, 32'h0, 1'b1, 32'h77);
    #1;
    chk("fwd_pop", bus.ReadData, 32'h9);
    step();
    #1;
    chk("fwd_after_pop", bus.ReadData, 32'h77);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_valid", bus.MemValid, 1'b0);
    step();
    step();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    repeat (3) step();
    #1;
    chk("rst_mid_empty", bus.Empty, 1'b1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic rdy;
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        q.delete();
      end
      if ((n % 1000) < 500) rdy = ($urandom_range(0, 3) == 0);
      else                  rdy = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)),
            32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3)),
            $urandom, rdy, $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
